// File: rtl/rgb888_word_unpacker_pkg.sv
// Shared constants, pixel payload type and frame-geometry helper for the RGB888 word unpacker.
package rgb888_word_unpacker_pkg;

    localparam int unsigned BytesPerPixel = 3;
    localparam int unsigned BytesPerWord  = 4;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb888_t;

    typedef enum logic {
        ST_STREAM,
        ST_FLUSH
    } unpack_state_e;

    function automatic int unsigned words_per_frame(input int unsigned height,
                                                    input int unsigned width);
        return (height * width * BytesPerPixel) / BytesPerWord;
    endfunction

endpackage

// File: rtl/rgb888_word_unpacker.sv
// Unpacks a 32-bit word stream of tightly packed RGB888 bytes into one pixel per handshake.
// Optional frame/error statistics ports are enabled with RGB888_UNPACKER_STATS_EN.
module rgb888_word_unpacker
    import rgb888_word_unpacker_pkg::*;
#(
    parameter int unsigned Height = 600,
    parameter int unsigned Width  = 800
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        slave_valid_i,
    output logic        slave_ready_o,
    input  logic [31:0] slave_data_i,
    input  logic        slave_last_i,
    output logic        master_valid_o,
    input  logic        master_ready_i,
    output logic [7:0]  master_red_o,
    output logic [7:0]  master_green_o,
    output logic [7:0]  master_blue_o,
    output logic        master_last_o,
    output logic        frame_error_o
`ifdef RGB888_UNPACKER_STATS_EN
   ,output logic [15:0] frames_done_o,
    output logic [7:0]  errors_o
`endif
);

    localparam int unsigned Pixels = Height * Width;
    localparam int unsigned Words  = words_per_frame(Height, Width);
    localparam int unsigned PixW   = $clog2(Pixels);
    localparam int unsigned WordW  = $clog2(Words);
    localparam int unsigned CntW   = 3;

    if ((Pixels % 4) != 0) begin : g_geometry_check
        $error("rgb888_word_unpacker: Height*Width must be a multiple of 4");
    end

    unpack_state_e    state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [5:0][7:0]  buf_q, buf_d;
    logic [PixW-1:0]  pix_idx_q, pix_idx_d;
    logic [WordW-1:0] word_idx_q, word_idx_d;
    logic             err_q, err_d;

    logic    accept_c;
    logic    fire_c;
    logic    flush_final_c;
    rgb888_t head_px_c;

    // Handshake and pixel view are pure decodes of the registered byte store.
    assign slave_ready_o  = (cnt_q < CntW'(BytesPerPixel));
    assign master_valid_o = (cnt_q >= CntW'(BytesPerPixel));
    assign accept_c       = slave_valid_i && slave_ready_o;
    assign fire_c         = master_valid_o && master_ready_i;

    // After an early last, the final whole pixel is the one leaving fewer than 3 bytes behind.
    assign flush_final_c  = (state_q == ST_FLUSH) && (cnt_q < CntW'(2 * BytesPerPixel));

    assign head_px_c.red   = buf_q[0];
    assign head_px_c.green = buf_q[1];
    assign head_px_c.blue  = buf_q[2];

    assign master_red_o   = head_px_c.red;
    assign master_green_o = head_px_c.green;
    assign master_blue_o  = head_px_c.blue;
    assign master_last_o  = master_valid_o &&
                            ((pix_idx_q == PixW'(Pixels - 1)) || flush_final_c);
    assign frame_error_o  = err_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_STREAM;
            cnt_q      <= '0;
            buf_q      <= '0;
            pix_idx_q  <= '0;
            word_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            pix_idx_q  <= pix_idx_d;
            word_idx_q <= word_idx_d;
            err_q      <= err_d;
        end
    end

    // Accept and pop are mutually exclusive: ready needs cnt<3, valid needs cnt>=3.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        pix_idx_d  = pix_idx_q;
        word_idx_d = word_idx_q;
        err_d      = 1'b0;

        if (accept_c) begin
            unique case (cnt_q)
                3'd0:    buf_d[3:0] = slave_data_i;
                3'd1:    buf_d[4:1] = slave_data_i;
                3'd2:    buf_d[5:2] = slave_data_i;
                default: buf_d      = buf_q;
            endcase
            cnt_d = cnt_q + CntW'(BytesPerWord);

            if (slave_last_i) begin
                word_idx_d = '0;
                if (word_idx_q != WordW'(Words - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_FLUSH;
                end
            end else if (word_idx_q == WordW'(Words - 1)) begin
                word_idx_d = '0;
                err_d      = 1'b1;
            end else begin
                word_idx_d = word_idx_q + WordW'(1);
            end
        end else if (fire_c) begin
            buf_d[2:0] = buf_q[5:3];
            buf_d[5:3] = '0;
            cnt_d      = cnt_q - CntW'(BytesPerPixel);
            pix_idx_d  = master_last_o ? '0 : pix_idx_q + PixW'(1);

            // Truncated frame: drop the 1-2 leftover bytes and restart at pixel 0.
            if (flush_final_c) begin
                state_d   = ST_STREAM;
                cnt_d     = '0;
                buf_d     = '0;
                pix_idx_d = '0;
            end
        end
    end

`ifdef RGB888_UNPACKER_STATS_EN
    logic [15:0] frames_done_q;
    logic [7:0]  errors_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            frames_done_q <= '0;
            errors_q      <= '0;
        end else begin
            if (fire_c && master_last_o) begin
                frames_done_q <= frames_done_q + 16'd1;
            end
            if (err_q && (errors_q != 8'hFF)) begin
                errors_q <= errors_q + 8'd1;
            end
        end
    end

    assign frames_done_o = frames_done_q;
    assign errors_o      = errors_q;
`endif

endmodule

// File: tb/tb_rgb888_word_unpacker.sv
// Scoreboard bench for rgb888_word_unpacker on a 2x2 frame (3 words, 4 pixels per frame).
module tb_rgb888_word_unpacker;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        slave_valid_i = 1'b0;
    logic        slave_ready_o;
    logic [31:0] slave_data_i = '0;
    logic        slave_last_i = 1'b0;
    logic        master_valid_o;
    logic        master_ready_i = 1'b0;
    logic [7:0]  master_red_o;
    logic [7:0]  master_green_o;
    logic [7:0]  master_blue_o;
    logic        master_last_o;
    logic        frame_error_o;
`ifdef RGB888_UNPACKER_STATS_EN
    logic [15:0] frames_done_o;
    logic [7:0]  errors_o;
`endif

    rgb888_word_unpacker #(.Height(2), .Width(2)) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .slave_valid_i  (slave_valid_i),
        .slave_ready_o  (slave_ready_o),
        .slave_data_i   (slave_data_i),
        .slave_last_i   (slave_last_i),
        .master_valid_o (master_valid_o),
        .master_ready_i (master_ready_i),
        .master_red_o   (master_red_o),
        .master_green_o (master_green_o),
        .master_blue_o  (master_blue_o),
        .master_last_o  (master_last_o),
        .frame_error_o  (frame_error_o)
`ifdef RGB888_UNPACKER_STATS_EN
       ,.frames_done_o  (frames_done_o),
        .errors_o       (errors_o)
`endif
    );

    always #5 clock_i = ~clock_i;

    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;
    logic [24:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic push_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input logic l);
        exp_q.push_back({r, g, b, l});
    endtask

    // Monitor: pops an expected pixel on every fired handshake and counts error pulses.
    always @(negedge clock_i) begin
        if (!reset_i) begin
            if (master_valid_o && master_ready_i) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_pixel");
                end else begin
                    logic [24:0] e;
                    e = exp_q.pop_front();
                    check("pixel_rgb_last",
                          {7'd0, master_red_o, master_green_o, master_blue_o, master_last_o},
                          {7'd0, e});
                end
            end
            if (frame_error_o) err_seen++;
        end
    end

    task automatic send_word(input logic [31:0] d, input logic l);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        slave_valid_i = 1'b1;
        slave_data_i  = d;
        slave_last_i  = l;
        while (!done) begin
            @(negedge clock_i);
            if (slave_ready_o) done = 1'b1;
            else if (++n > 200) begin
                fail_now("send_word_timeout");
                done = 1'b1;
            end
        end
        @(posedge clock_i);
        #1;
        slave_valid_i = 1'b0;
        slave_last_i  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clock_i);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
        end
        repeat (3) @(posedge clock_i);
        #1;
    endtask

    task automatic push_base_frame();
        push_px(8'h11, 8'h22, 8'h33, 1'b0);
        push_px(8'h44, 8'h55, 8'h66, 1'b0);
        push_px(8'h77, 8'h88, 8'h99, 1'b0);
        push_px(8'hAA, 8'hBB, 8'hCC, 1'b1);
    endtask

    task automatic push_alt_frame();
        push_px(8'hA0, 8'hA1, 8'hA2, 1'b0);
        push_px(8'hA3, 8'hA4, 8'hA5, 1'b0);
        push_px(8'hA6, 8'hA7, 8'hA8, 1'b0);
        push_px(8'hA9, 8'hAA, 8'hAB, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] words[3];
        logic        exp_ready[8];
        int          wi;
        int          err_base;
        logic        acc;

        words[0] = 32'h4433_2211;
        words[1] = 32'h8877_6655;
        words[2] = 32'hCCBB_AA99;
        exp_ready[0] = 1'b1; exp_ready[1] = 1'b0; exp_ready[2] = 1'b1; exp_ready[3] = 1'b0;
        exp_ready[4] = 1'b1; exp_ready[5] = 1'b0; exp_ready[6] = 1'b0; exp_ready[7] = 1'b1;

        // Reset state
        repeat (3) @(posedge clock_i);
        @(negedge clock_i);
        check("reset_outputs",
              {6'd0, master_valid_o, master_red_o, master_green_o, master_blue_o,
               master_last_o, frame_error_o}, 32'd0);
        check("reset_slave_ready", {31'd0, slave_ready_o}, 32'd1);
        @(posedge clock_i);
        #1;
        reset_i = 1'b0;

        // Basic decode with continuous ready: count sequence 0,4,1,5,2,6,3,0
        master_ready_i = 1'b1;
        err_base = err_seen;
        push_base_frame();
        wi = 0;
        slave_valid_i = 1'b1;
        slave_data_i  = words[0];
        slave_last_i  = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock_i);
            check($sformatf("ready_seq_%0d", c), {31'd0, slave_ready_o}, {31'd0, exp_ready[c]});
            acc = slave_ready_o && slave_valid_i;
            @(posedge clock_i);
            #1;
            if (acc) begin
                wi++;
                if (wi < 3) begin
                    slave_data_i = words[wi];
                    slave_last_i = (wi == 2);
                end else begin
                    slave_valid_i = 1'b0;
                    slave_last_i  = 1'b0;
                end
            end
        end
        drain();
        check("basic_no_error", 32'(err_seen - err_base), 32'd0);

        // Second frame repeats identically
        err_base = err_seen;
        push_base_frame();
        send_word(words[0], 1'b0);
        send_word(words[1], 1'b0);
        send_word(words[2], 1'b1);
        drain();
        check("second_frame_no_error", 32'(err_seen - err_base), 32'd0);

        // Downstream stall with a pixel pending
        err_base = err_seen;
        master_ready_i = 1'b0;
        push_base_frame();
        send_word(words[0], 1'b0);
        slave_valid_i = 1'b1;
        slave_data_i  = words[1];
        for (int c = 0; c < 5; c++) begin
            @(negedge clock_i);
            check("stall_hold",
                  {6'd0, master_valid_o, master_red_o, master_green_o, master_blue_o,
                   master_last_o, slave_ready_o},
                  {6'd0, 1'b1, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0});
        end
        @(posedge clock_i);
        #1;
        master_ready_i = 1'b1;
        send_word(words[1], 1'b0);
        send_word(words[2], 1'b1);
        drain();
        check("stall_no_error", 32'(err_seen - err_base), 32'd0);

        // Early last on word 1: two pixels, second flagged last, 2 bytes dropped
        err_base = err_seen;
        push_px(8'h01, 8'h02, 8'h03, 1'b0);
        push_px(8'h04, 8'h05, 8'h06, 1'b1);
        send_word(32'h0403_0201, 1'b0);
        send_word(32'h0807_0605, 1'b1);
        drain();
        check("early_last_error", 32'(err_seen - err_base), 32'd1);
        err_base = err_seen;
        push_base_frame();
        send_word(words[0], 1'b0);
        send_word(words[1], 1'b0);
        send_word(words[2], 1'b1);
        drain();
        check("after_early_clean", 32'(err_seen - err_base), 32'd0);

        // Missing last on word 2, then a properly terminated frame
        err_base = err_seen;
        push_base_frame();
        send_word(words[0], 1'b0);
        send_word(words[1], 1'b0);
        send_word(words[2], 1'b0);
        drain();
        check("missing_last_error", 32'(err_seen - err_base), 32'd1);
        err_base = err_seen;
        push_alt_frame();
        send_word(32'hA3A2_A1A0, 1'b0);
        send_word(32'hA7A6_A5A4, 1'b0);
        send_word(32'hABAA_A9A8, 1'b1);
        drain();
        check("after_missing_clean", 32'(err_seen - err_base), 32'd0);

        // Asynchronous reset mid-frame with 5 bytes buffered
        push_px(8'h11, 8'h22, 8'h33, 1'b0);
        send_word(words[0], 1'b0);
        send_word(words[1], 1'b0);
        master_ready_i = 1'b0;
        @(negedge clock_i);
        check("pre_reset_cnt5",
              {7'd0, master_valid_o, master_red_o, master_green_o, master_blue_o, slave_ready_o},
              {7'd0, 1'b1, 8'h44, 8'h55, 8'h66, 1'b0});
        #2;
        reset_i = 1'b1;
        #1;
        check("async_reset_outputs",
              {6'd0, master_valid_o, master_red_o, master_green_o, master_blue_o,
               master_last_o, frame_error_o}, 32'd0);
        check("async_reset_ready", {31'd0, slave_ready_o}, 32'd1);
        repeat (2) @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        master_ready_i = 1'b1;
        err_base = err_seen;
        push_alt_frame();
        send_word(32'hA3A2_A1A0, 1'b0);
        send_word(32'hA7A6_A5A4, 1'b0);
        send_word(32'hABAA_A9A8, 1'b1);
        drain();
        check("post_reset_no_error", 32'(err_seen - err_base), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
